alu_sequencer: RTL and testbench

Multi-cycle issue/write-back controller that drives the ALU from the other side of its interface. It accepts 16-bit register-register instructions over a valid/ready handshake and holds a 16-entry register file. It presents operands and opcode to the external combinational ALU, captures the ALU result, and writes it back. It sits between instruction fetch and the ALU in the small CPU datapath.

---
 rtl/alu_sequencer_if.sv | 28 ++
 rtl/alu_sequencer.sv | 79 +++++++
 tb/tb_alu_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bundle between the sequencer and its neighbours: fetch handshake, ALU drive/return,
// retire reporting and the debug register-read port.
interface alu_sequencer_if #(
   parameter int N = 16
);
   logic [15:0]  instr;
   logic         instr_valid;
   logic         instr_ready;
   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_op;
   logic [N-1:0] alu_out;
   logic         done;
   logic [N-1:0] result;
   logic         err;
   logic [3:0]   dbg_addr;
   logic [N-1:0] dbg_data;

   modport slave (
      input  instr, instr_valid, alu_out, dbg_addr,
      output instr_ready, alu_a, alu_b, alu_op, done, result, err, dbg_data
   );

   modport master (
      output instr, instr_valid, alu_out, dbg_addr,
      input  instr_ready, alu_a, alu_b, alu_op, done, result, err, dbg_data
   );
endinterface

// File: rtl/alu_sequencer.sv
// Three-state issue/write-back controller: accepts one instruction, drives the external
// combinational ALU from registered operands, writes the result back to a 16-entry file.
module alu_sequencer #(
   parameter int N = 16
) (
   input logic            clk,
   input logic            rst_n,
   alu_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   state_t       state;
   logic [15:0]  ir;
   logic [N-1:0] regs [16];

   logic [3:0]   op, rd, rs1, rs2;
   logic [N-1:0] imm;

   assign op  = ir[15:12];
   assign rd  = ir[11:8];
   assign rs1 = ir[7:4];
   assign rs2 = ir[3:0];
   assign imm = {{(N-8){ir[7]}}, ir[7:0]};

   // R[0] is never written, so it always reads back as zero.
   assign bus.dbg_data = regs[bus.dbg_addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         ir              <= '0;
         bus.instr_ready <= 1'b1;
         bus.alu_a       <= '0;
         bus.alu_b       <= '0;
         bus.alu_op      <= '0;
         bus.done        <= 1'b0;
         bus.result      <= '0;
         bus.err         <= 1'b0;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.instr_valid && bus.instr_ready) begin
                  ir              <= bus.instr;
                  bus.instr_ready <= 1'b0;
                  state           <= EXEC;
               end
            end
            EXEC: begin
               // Operands are frozen here and held through WB so alu_out is settled when sampled.
               if (!op[3]) begin
                  bus.alu_a  <= regs[rs1];
                  bus.alu_b  <= regs[rs2];
                  bus.alu_op <= op;
               end
               state <= WB;
            end
            WB: begin
               if (!op[3]) begin
                  if (rd != 4'd0) regs[rd] <= bus.alu_out;
                  bus.result <= bus.alu_out;
                  bus.done   <= 1'b1;
               end else if (op == 4'hF) begin
                  if (rd != 4'd0) regs[rd] <= imm;
                  bus.result <= imm;
                  bus.done   <= 1'b1;
               end else begin
                  bus.err <= 1'b1;
               end
               bus.instr_ready <= 1'b1;
               state           <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with a behavioural ALU and register model.
module tb_alu_sequencer;
   localparam int N = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] dbg_sel = 4'd0;
   always #5 clk = ~clk;

   alu_sequencer_if #(.N(N)) bus ();
   alu_sequencer #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   assign bus.dbg_addr = dbg_sel;

   // External combinational ALU
   always_comb begin
      bus.alu_out = '0;
      case (bus.alu_op)
         4'd0: bus.alu_out = bus.alu_a + bus.alu_b;
         4'd1: bus.alu_out = bus.alu_a ^ bus.alu_b;
         4'd2: bus.alu_out = bus.alu_a | bus.alu_b;
         4'd3: bus.alu_out = bus.alu_a & bus.alu_b;
         4'd4: bus.alu_out = (bus.alu_a == bus.alu_b) ? 16'd1 : 16'd0;
         4'd5: bus.alu_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 16'd1 : 16'd0;
         4'd6: bus.alu_out = bus.alu_a << bus.alu_b[3:0];
         4'd7: bus.alu_out = bus.alu_a >> bus.alu_b[3:0];
         default: bus.alu_out = '0;
      endcase
   end

   typedef struct {
      logic [3:0]   rd;
      logic         is_err;
      logic [N-1:0] res;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [3:0]   aop;
      logic [N-1:0] regv;
      int           acc_cyc;
   } exp_t;

   exp_t sb[$];
   logic [N-1:0] mr [16];
   logic [N-1:0] m_res, m_a, m_b;
   logic [3:0]   m_op;
   int tests = 0, fails = 0, cyc = 0, n_acc = 0, n_done = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] ref_alu(input logic [3:0] op, input int a, input int b);
      int r;
      case (op)
         4'd0: r = a + b;
         4'd1: r = a ^ b;
         4'd2: r = a | b;
         4'd3: r = a & b;
         4'd4: r = (a == b) ? 1 : 0;
         4'd5: r = (((a >= 32768) ? a - 65536 : a) < ((b >= 32768) ? b - 65536 : b)) ? 1 : 0;
         4'd6: r = a * (1 << (b % 16));
         default: r = a / (1 << (b % 16));
      endcase
      return r[N-1:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mr[i] = '0;
      m_res = '0; m_a = '0; m_b = '0; m_op = '0;
   endtask

   // Predict the architectural effect of one accepted instruction.
   task automatic predict(input logic [15:0] ins);
      exp_t e;
      logic [3:0] op, rd, rs1, rs2;
      logic [7:0] lo;
      int v;
      op = ins[15:12]; rd = ins[11:8]; rs1 = ins[7:4]; rs2 = ins[3:0];
      lo = ins[7:0];
      e.is_err = 1'b0;
      if (op < 4'd8) begin
         m_a = mr[rs1]; m_b = mr[rs2]; m_op = op;
         m_res = ref_alu(op, int'(mr[rs1]), int'(mr[rs2]));
         if (rd != 0) mr[rd] = m_res;
      end else if (op == 4'hF) begin
         v = (lo >= 8'd128) ? int'(lo) - 256 : int'(lo);
         m_res = v[N-1:0];
         if (rd != 0) mr[rd] = m_res;
      end else begin
         e.is_err = 1'b1;
      end
      e.rd = rd; e.res = m_res; e.a = m_a; e.b = m_b; e.aop = m_op;
      e.regv = mr[rd]; e.acc_cyc = cyc;
      sb.push_back(e);
   endtask

   // Present ins and hold it (valid stays high afterwards) until the DUT takes it.
   task automatic issue(input logic [15:0] ins, input bit track);
      bit got, rdy;
      got = 0;
      @(negedge clk);
      bus.instr = ins; bus.instr_valid = 1'b1;
      for (int t = 0; t < 20; t++) begin
         rdy = bus.instr_ready;
         @(posedge clk);
         if (rdy) begin got = 1; break; end
         @(negedge clk);
      end
      #1;
      if (!got) begin
         tests++; fails++;
         $display("FAIL accept_timeout: instr %0h never accepted", ins);
         bus.instr_valid = 1'b0;
      end else if (track) begin
         n_acc++;
         predict(ins);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.done || bus.err) begin
         if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_retire: done=%0b err=%0b with nothing outstanding", bus.done, bus.err);
         end else begin
            e = sb.pop_front();
            n_done++;
            chk("done", bus.done, !e.is_err);
            chk("err", bus.err, e.is_err);
            chk("result", bus.result, e.res);
            chk("alu_a", bus.alu_a, e.a);
            chk("alu_b", bus.alu_b, e.b);
            chk("alu_op", bus.alu_op, e.aop);
            chk("latency", cyc - e.acc_cyc, 2);
            dbg_sel = e.rd;
            #1;
            chk("reg_after_wb", bus.dbg_data, e.regv);
         end
      end
   end

   task automatic read_reg(input logic [3:0] a, input logic [N-1:0] exp, input string nm);
      dbg_sel = a;
      #1;
      chk(nm, bus.dbg_data, exp);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ready"}, bus.instr_ready, 1);
      chk({nm, "_alu_a"}, bus.alu_a, 0);
      chk({nm, "_alu_b"}, bus.alu_b, 0);
      chk({nm, "_alu_op"}, bus.alu_op, 0);
      chk({nm, "_done"}, bus.done, 0);
      chk({nm, "_result"}, bus.result, 0);
      chk({nm, "_err"}, bus.err, 0);
   endtask

   task automatic drain();
      for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) begin
         tests++; fails++;
         $display("FAIL drain_timeout: %0d retirements outstanding", sb.size());
      end
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] op;
      int v;
      bus.instr = '0; bus.instr_valid = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      read_reg(4'd7, 16'h0000, "rst_reg");
      rst_n = 1'b1;
      @(negedge clk);

      // Directed sequence; each issue holds valid through EXEC/WB of the previous one.
      issue(16'hF105, 1);   // LI r1,0x05
      issue(16'hF2FF, 1);   // LI r2,0xFF
      issue(16'h0312, 1);   // ADD r3,r1,r2
      issue(16'h5413, 1);   // SLT r4,r1,r3
      issue(16'h4533, 1);   // SEQ r5,r3,r3
      issue(16'h9123, 1);   // illegal
      issue(16'hF07F, 1);   // LI r0,0x7F
      bus.instr_valid = 1'b0;
      drain();
      read_reg(4'd1, 16'h0005, "r1");
      read_reg(4'd2, 16'hFFFF, "r2");
      read_reg(4'd3, 16'h0004, "r3");
      read_reg(4'd4, 16'h0000, "r4");
      read_reg(4'd5, 16'h0001, "r5");
      read_reg(4'd0, 16'h0000, "r0");

      // Reset during EXEC of XOR r6,r1,r2.
      issue(16'h1612, 0);
      @(negedge clk);
      rst_n = 1'b0;
      bus.instr_valid = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_ready_after", bus.instr_ready, 1);
      read_reg(4'd6, 16'h0000, "midrst_r6");
      read_reg(4'd1, 16'h0000, "midrst_r1");

      // Random traffic with occasional idle gaps.
      for (int i = 0; i < 300; i++) begin
         v = $urandom_range(0, 19);
         if (v < 12)      op = 4'(v % 8);
         else if (v < 17) op = 4'hF;
         else             op = 4'(8 + $urandom_range(0, 6));
         issue({op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))}, 1);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
      end
      bus.instr_valid = 1'b0;
      drain();
      chk("retire_count", n_done, n_acc);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end
endmodule
